// File: rtl/openmips_min_sopc.sv
// Minimal SOPC: five-stage ORI-only MIPS32 core and a 1024-word instruction ROM.
// The ROM image is placed into mem by the loader before reset is released.
module openmips_min_sopc (
    input  logic clk,
    input  logic rst
);

    typedef struct packed {
        logic [31:0] inst;
    } if_id_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  wd;
        logic [31:0] op1;
        logic [15:0] imm;
    } id_ex_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  wd;
        logic [31:0] wdata;
    } wb_t;

    localparam logic [5:0] OP_ORI = 6'b001101;

    logic [31:0] mem [0:1023];
    logic [31:0] pc;
    logic        rom_ce;
    logic [31:0] inst;
    logic [31:0] regs [0:31];

    if_id_t if_id_q;
    id_ex_t id_ex_q, id_ex_d;
    wb_t    ex_mem_q, ex_mem_d;
    wb_t    mem_wb_q, mem_wb_d;

    logic [4:0]  id_rs;
    logic [31:0] id_rs_val;

    assign inst = rom_ce ? mem[pc[11:2]] : 32'h0;

    // PC holds at 0 for the first enabled cycle, then advances one word per clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= 32'h0;
            rom_ce <= 1'b0;
        end else begin
            rom_ce <= 1'b1;
            if (rom_ce) begin
                pc <= pc + 32'd4;
            end
        end
    end

    // IF/ID latch of the fetched word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id_q <= '0;
        end else begin
            if_id_q.inst <= inst;
        end
    end

    assign id_rs = if_id_q.inst[25:21];

    // Operand fetch: EX result beats MEM result beats the register file.
    always_comb begin
        id_rs_val = 32'h0;
        if (id_rs == 5'd0) begin
            id_rs_val = 32'h0;
        end else if (ex_mem_d.we && ex_mem_d.wd == id_rs) begin
            id_rs_val = ex_mem_d.wdata;
        end else if (mem_wb_d.we && mem_wb_d.wd == id_rs) begin
            id_rs_val = mem_wb_d.wdata;
        end else if (mem_wb_q.we && mem_wb_q.wd == id_rs) begin
            id_rs_val = mem_wb_q.wdata;
        end else begin
            id_rs_val = regs[id_rs];
        end
    end

    // Decode: only ORI writes back; everything else becomes a bubble.
    always_comb begin
        id_ex_d = '0;
        if (if_id_q.inst[31:26] == OP_ORI) begin
            id_ex_d.we  = 1'b1;
            id_ex_d.wd  = if_id_q.inst[20:16];
            id_ex_d.op1 = id_rs_val;
            id_ex_d.imm = if_id_q.inst[15:0];
        end
    end

    // ID/EX register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    // Execute the OR with the zero-extended immediate.
    always_comb begin
        ex_mem_d       = '0;
        ex_mem_d.we    = id_ex_q.we;
        ex_mem_d.wd    = id_ex_q.wd;
        ex_mem_d.wdata = id_ex_q.op1 | {16'h0, id_ex_q.imm};
    end

    // EX/MEM register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_mem_q <= '0;
        end else begin
            ex_mem_q <= ex_mem_d;
        end
    end

    // MEM has no memory access, so it forwards its inputs untouched.
    always_comb begin
        mem_wb_d = ex_mem_q;
    end

    // MEM/WB register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wb_q <= '0;
        end else begin
            mem_wb_q <= mem_wb_d;
        end
    end

    // Register file write; $0 is never written so it always reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'h0;
            end
        end else if (mem_wb_q.we && mem_wb_q.wd != 5'd0) begin
            regs[mem_wb_q.wd] <= mem_wb_q.wdata;
        end
    end

endmodule

// File: tb/tb_openmips_min_sopc.sv
// Bench for openmips_min_sopc: loads small ORI programs into the ROM and
// checks PC and register contents edge by edge through a scoreboard.
module tb_openmips_min_sopc;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int nchk = 0;
    int nerr = 0;

    typedef struct {
        int          e;
        int          kind;
        int          idx;
        logic [31:0] val;
    } exp_t;

    exp_t sbq[$];

    openmips_min_sopc dut (
        .clk(clk),
        .rst(rst)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] regs_or();
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < 32; i++) begin
            v = v | dut.regs[i];
        end
        return v;
    endfunction

    function automatic void push(input int e, input int kind, input int idx,
                                 input logic [31:0] val);
        exp_t x;
        x.e    = e;
        x.kind = kind;
        x.idx  = idx;
        x.val  = val;
        sbq.push_back(x);
    endfunction

    task automatic load(input logic [31:0] w0, input logic [31:0] w1,
                        input logic [31:0] w2, input logic [31:0] w3);
        for (int i = 0; i < 16; i++) begin
            dut.mem[i] = 32'h0;
        end
        dut.mem[0] = w0;
        dut.mem[1] = w1;
        dut.mem[2] = w2;
        dut.mem[3] = w3;
    endtask

    task automatic drain(input int e);
        exp_t        x;
        logic [31:0] got;
        while (sbq.size() > 0 && sbq[0].e == e) begin
            x = sbq.pop_front();
            case (x.kind)
                0:       got = dut.pc;
                1:       got = {31'h0, dut.rom_ce};
                2:       got = dut.regs[x.idx];
                default: got = regs_or();
            endcase
            chk($sformatf("k%0d_r%0d_e%0d", x.kind, x.idx, e), got, x.val);
        end
    endtask

    task automatic run_edges(input int n);
        for (int e = 1; e <= n; e++) begin
            @(posedge clk);
            @(negedge clk);
            drain(e);
        end
        chk("sb_leftover", sbq.size(), 0);
        sbq.delete();
    endtask

    // Assert reset off the clock edge and check the asynchronous clear.
    task automatic apply_reset(input string tag, input int ns);
        #2;
        rst = 1'b1;
        #1;
        chk({tag, "_pc"}, dut.pc, 32'h0);
        chk({tag, "_ce"}, {31'h0, dut.rom_ce}, 32'h0);
        chk({tag, "_regs"}, regs_or(), 32'h0);
        #(ns - 1);
        rst = 1'b0;
    endtask

    task automatic push_indep();
        push(1, 0, 0, 32'h0);
        push(1, 1, 0, 32'h1);
        push(2, 0, 0, 32'h4);
        push(3, 0, 0, 32'h8);
        push(4, 0, 0, 32'hc);
        push(5, 3, 0, 32'h0);
        push(6, 2, 1, 32'h0000_1100);
        push(6, 2, 2, 32'h0);
        push(7, 2, 2, 32'h0000_0020);
        push(7, 2, 3, 32'h0);
        push(8, 2, 3, 32'h0000_ff00);
        push(8, 2, 4, 32'h0);
        push(9, 2, 4, 32'h0000_ffff);
        push(10, 2, 1, 32'h0000_1100);
    endtask

    initial begin
        // Reset state and independent ORIs
        #1;
        rst = 1'b1;
        load(32'h3401_1100, 32'h3402_0020, 32'h3403_ff00, 32'h3404_ffff);
        #4;
        chk("rst_pc", dut.pc, 32'h0);
        chk("rst_ce", {31'h0, dut.rom_ce}, 32'h0);
        chk("rst_regs", regs_or(), 32'h0);
        #190;
        rst = 1'b0;
        push_indep();
        run_edges(10);

        // Dependent chain through the forwarding paths
        apply_reset("rst2", 30);
        load(32'h3401_1100, 32'h3421_0020, 32'h3422_4400, 32'h3443_0044);
        push(5, 3, 0, 32'h0);
        push(6, 2, 1, 32'h0000_1100);
        push(7, 2, 1, 32'h0000_1120);
        push(8, 2, 2, 32'h0000_5520);
        push(9, 2, 3, 32'h0000_5564);
        push(10, 2, 1, 32'h0000_1120);
        push(10, 2, 2, 32'h0000_5520);
        run_edges(10);

        // Writes to $0 and non-ORI words are dropped
        apply_reset("rst3", 30);
        load(32'h3400_0055, 32'h0000_0000, 32'h3405_abcd, 32'h0000_0000);
        push(6, 2, 0, 32'h0);
        push(7, 3, 0, 32'h0);
        push(8, 2, 5, 32'h0000_abcd);
        push(10, 2, 0, 32'h0);
        push(10, 3, 0, 32'h0000_abcd);
        run_edges(10);

        // Mid-run reset discards in-flight instructions
        apply_reset("rst4", 30);
        load(32'h3401_1100, 32'h3402_0020, 32'h3403_ff00, 32'h3404_ffff);
        push(4, 0, 0, 32'hc);
        run_edges(4);
        apply_reset("rst_mid", 30);
        push(1, 0, 0, 32'h0);
        push(1, 3, 0, 32'h0);
        push(2, 0, 0, 32'h4);
        push(5, 3, 0, 32'h0);
        push(6, 2, 1, 32'h0000_1100);
        push(7, 2, 2, 32'h0000_0020);
        run_edges(7);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
